// File: rtl/ff_bist_pkg.sv
// ff_bist_pkg: shared types and constants for the flip-flop BIST engine.
//   state_e    - BIST sequencer states
//   TAP_MASK   - feedback taps of the 8-bit LFSR (bits 7,5,4,3)
//   DEF_SEED   - default LFSR seed
//   RST_CYCLES - cycles the DUT is held in reset before data is driven
//   seed_fix() - maps an all-zero seed (LFSR lock-up) to 8'h01
`timescale 1ns/1ps
package ff_bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_DUT = 3'd1,
    RUN     = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [7:0] TAP_MASK   = 8'hB8;
  localparam logic [7:0] DEF_SEED   = 8'hA5;
  localparam int         RST_CYCLES = 2;

  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/ff_bist_if.sv
// ff_bist_if: control/status and DUT-side signals of the BIST engine.
//   start     - launch pulse (harness -> bist)
//   busy/done/pass/err_count - status (bist -> harness)
//   dut_rst/dut_d - stimulus to the flop under test
//   dut_q     - response from the flop under test
// modport slave is the BIST engine, modport master is the harness.
`timescale 1ns/1ps
interface ff_bist_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic             dut_rst;
  logic             dut_d;
  logic             dut_q;

  modport slave (
    input  start, dut_q,
    output busy, done, pass, err_count, dut_rst, dut_d
  );

  modport master (
    output start, dut_q,
    input  busy, done, pass, err_count, dut_rst, dut_d
  );
endinterface

// File: rtl/ff_bist_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, shifting left, feedback into bit 0.
//   clk, rst (async active-low) - reset loads RST_SEED
//   load  - reload from seed (priority over en)
//   en    - advance one step
//   seed  - reload value
//   state - current LFSR contents
// An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
`timescale 1ns/1ps
module lfsr8
  import ff_bist_pkg::*;
#(
  parameter logic [7:0] RST_SEED = DEF_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      state <= seed_fix(RST_SEED);
    else if (load) state <= seed_fix(seed);
    else if (en)   state <= {state[6:0], ^(state & TAP_MASK)};
  end

endmodule

// File: rtl/ff_bist.sv
// ff_bist: built-in self-test for a single-bit D flop.
//   clk  - rising-edge clock
//   rst  - async active-low reset
//   bus  - ff_bist_if.slave: start in; busy/done/pass/err_count out;
//          dut_rst/dut_d out to the flop, dut_q back from it
// Sequence: hold the DUT in reset for RST_CYCLES (q must read 0 in the
// last reset cycle), drive NUM_VECTORS LFSR bits, compare each q one
// cycle after the bit was presented, then report. err_count saturates.
`timescale 1ns/1ps
module ff_bist
  import ff_bist_pkg::*;
#(
  parameter int         NUM_VECTORS = 16,
  parameter logic [7:0] LFSR_SEED   = DEF_SEED,
  parameter int         CNT_W       = 8
) (
  input logic clk,
  input logic rst,
  ff_bist_if.slave bus
);

  localparam int VC_W = 8;
  localparam int RC_W = $clog2(RST_CYCLES);

  state_e            st;
  logic [VC_W-1:0]   vcnt;   // vectors driven so far
  logic [RC_W-1:0]   rcnt;
  logic              d_prev;
  logic              busy_r, done_r, dut_rst_r, dut_d_r;
  logic [CNT_W-1:0]  err;
  logic [7:0]        lfsr;

  logic lfsr_load, lfsr_en, rst_last, rst_chk, data_chk, miss;

  always_comb begin
    rst_last  = (st == RST_DUT) && (rcnt == RC_W'(RST_CYCLES - 1));
    lfsr_load = ((st == IDLE) || (st == DONE)) && bus.start;
    // first vector leaves on the RST_DUT->RUN edge, the rest during RUN
    lfsr_en   = rst_last || ((st == RUN) && (vcnt < VC_W'(NUM_VECTORS)));
    rst_chk   = rst_last;
    // the first RUN cycle has no captured vector yet; FLUSH checks the last
    data_chk  = ((st == RUN) && (vcnt != VC_W'(1))) || (st == FLUSH);
    miss      = 1'b0;
    if (rst_chk)       miss = bus.dut_q;
    else if (data_chk) miss = bus.dut_q ^ d_prev;
  end

  lfsr8 #(.RST_SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      vcnt      <= '0;
      rcnt      <= '0;
      d_prev    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dut_rst_r <= 1'b0;
      dut_d_r   <= 1'b0;
      err       <= '0;
    end else begin
      if (miss && (err != {CNT_W{1'b1}})) err <= err + 1'b1;
      case (st)
        IDLE, DONE: begin
          if (bus.start) begin
            st        <= RST_DUT;
            err       <= '0;
            done_r    <= 1'b0;
            busy_r    <= 1'b1;
            dut_rst_r <= 1'b1;
            dut_d_r   <= 1'b0;
            rcnt      <= '0;
            vcnt      <= '0;
          end
        end
        RST_DUT: begin
          rcnt <= rcnt + RC_W'(1);
          if (rst_last) begin
            st        <= RUN;
            dut_rst_r <= 1'b0;
            dut_d_r   <= lfsr[7];
            vcnt      <= VC_W'(1);
          end
        end
        RUN: begin
          d_prev <= dut_d_r;
          if (vcnt < VC_W'(NUM_VECTORS)) begin
            dut_d_r <= lfsr[7];
            vcnt    <= vcnt + VC_W'(1);
          end else begin
            st <= FLUSH;
          end
        end
        FLUSH: begin
          st     <= DONE;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = done_r && (err == '0);
  assign bus.err_count = err;
  assign bus.dut_rst   = dut_rst_r;
  assign bus.dut_d     = dut_d_r;

endmodule

// File: tb/tb_ff_bist.sv
// tb_ff_bist: directed bench for ff_bist.
//   u_a: defaults, flop model selectable good/inverted plus a q glitch
//   u_b: NUM_VECTORS=1, flop stuck at 1
//   u_c: CNT_W=2, inverted flop (saturation and start handling)
`timescale 1ns/1ps
module tb_ff_bist;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ff_bist_if #(.CNT_W(8)) if_a ();
  ff_bist_if #(.CNT_W(8)) if_b ();
  ff_bist_if #(.CNT_W(2)) if_c ();

  ff_bist #(.NUM_VECTORS(16), .LFSR_SEED(8'hA5), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  ff_bist #(.NUM_VECTORS(1),  .LFSR_SEED(8'hA5), .CNT_W(8)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  ff_bist #(.NUM_VECTORS(16), .LFSR_SEED(8'hA5), .CNT_W(2)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  // flop models
  logic inv_a, glitch_a, q_a, q_c;
  always_ff @(posedge clk or posedge if_a.dut_rst)
    if (if_a.dut_rst) q_a <= 1'b0;
    else              q_a <= inv_a ? ~if_a.dut_d : if_a.dut_d;
  assign if_a.dut_q = q_a ^ glitch_a;

  assign if_b.dut_q = 1'b1;

  always_ff @(posedge clk or posedge if_c.dut_rst)
    if (if_c.dut_rst) q_c <= 1'b0;
    else              q_c <= ~if_c.dut_d;
  assign if_c.dut_q = q_c;

  int n_chk = 0;
  int n_err = 0;
  int edge_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); edge_n++; end
    #1;
  endtask

  task automatic to_edge(input int k);
    step(k - edge_n);
  endtask

  task automatic kick_a(); if_a.start = 1'b1; step(1); if_a.start = 1'b0; edge_n = 0; endtask
  task automatic kick_b(); if_b.start = 1'b1; step(1); if_b.start = 1'b0; edge_n = 0; endtask
  task automatic kick_c(); if_c.start = 1'b1; step(1); if_c.start = 1'b0; edge_n = 0; endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
    inv_a = 1'b0; glitch_a = 1'b0;
    step(2);
    chk("rst_busy",   if_a.busy, 0);
    chk("rst_done",   if_a.done, 0);
    chk("rst_pass",   if_a.pass, 0);
    chk("rst_err",    if_a.err_count, 0);
    chk("rst_dutrst", if_a.dut_rst, 0);
    chk("rst_d",      if_a.dut_d, 0);
    rst = 1'b1;
    step(5);

    // good flop, defaults; LFSR A5 -> first bits 1,0,1,0
    kick_a();
    chk("t1_busy0",   if_a.busy, 1);
    chk("t1_drst0",   if_a.dut_rst, 1);
    chk("t1_d0",      if_a.dut_d, 0);
    to_edge(1);  chk("t1_drst1", if_a.dut_rst, 1);
    to_edge(2);  chk("t1_drst2", if_a.dut_rst, 0);
                 chk("t1_v1",    if_a.dut_d, 1);
    to_edge(3);  chk("t1_v2",    if_a.dut_d, 0);
    to_edge(4);  chk("t1_v3",    if_a.dut_d, 1);
    to_edge(5);  chk("t1_v4",    if_a.dut_d, 0);
    to_edge(18); chk("t1_done18", if_a.done, 0);
                 chk("t1_busy18", if_a.busy, 1);
    to_edge(19); chk("t1_done19", if_a.done, 1);
                 chk("t1_pass",   if_a.pass, 1);
                 chk("t1_busy19", if_a.busy, 0);
                 chk("t1_err",    if_a.err_count, 0);

    // inverted flop, restarted from DONE
    inv_a = 1'b1;
    step(2);
    kick_a();
    chk("t2_done0", if_a.done, 0);
    to_edge(19); chk("t2_done", if_a.done, 1);
                 chk("t2_err",  if_a.err_count, 16);
                 chk("t2_pass", if_a.pass, 0);

    // good flop, q inverted during the 5th compare cycle
    inv_a = 1'b0;
    step(2);
    kick_a();
    chk("t3_err0", if_a.err_count, 0);
    to_edge(7);  glitch_a = 1'b1;
    to_edge(8);  glitch_a = 1'b0;
                 chk("t3_err8", if_a.err_count, 1);
    to_edge(19); chk("t3_done", if_a.done, 1);
                 chk("t3_err",  if_a.err_count, 1);
                 chk("t3_pass", if_a.pass, 0);

    // stuck-at-1, one vector: reset check fails, vector bit 1 matches
    kick_b();
    chk("t4_busy0", if_b.busy, 1);
    to_edge(2);  chk("t4_err2",  if_b.err_count, 1);
    to_edge(3);  chk("t4_done3", if_b.done, 0);
    to_edge(4);  chk("t4_done4", if_b.done, 1);
                 chk("t4_err",   if_b.err_count, 1);
                 chk("t4_pass",  if_b.pass, 0);
                 chk("t4_busy4", if_b.busy, 0);

    // reset mid-RUN
    inv_a = 1'b1;
    step(2);
    kick_a();
    to_edge(8);  chk("t5_err8", if_a.err_count, 5);
    rst = 1'b0;
    #1;
    chk("t5_busy",   if_a.busy, 0);
    chk("t5_done",   if_a.done, 0);
    chk("t5_err",    if_a.err_count, 0);
    chk("t5_drst",   if_a.dut_rst, 0);
    chk("t5_d",      if_a.dut_d, 0);
    chk("t5_b_done", if_b.done, 0);
    step(3);
    rst = 1'b1;
    step(12);
    chk("t5_nodone", if_a.done, 0);
    chk("t5_nobusy", if_a.busy, 0);
    inv_a = 1'b0;
    kick_a();
    to_edge(19); chk("t5_done2", if_a.done, 1);
                 chk("t5_pass2", if_a.pass, 1);

    // saturation, start ignored in RUN, restart from DONE
    kick_c();
    to_edge(4);  chk("t6_err4", if_c.err_count, 1);
    to_edge(6);  chk("t6_err6", if_c.err_count, 3);
    if_c.start = 1'b1;
    to_edge(7);  if_c.start = 1'b0;
                 chk("t6_busy7", if_c.busy, 1);
                 chk("t6_err7",  if_c.err_count, 3);
    to_edge(18); chk("t6_done18", if_c.done, 0);
    to_edge(19); chk("t6_done19", if_c.done, 1);
                 chk("t6_err",    if_c.err_count, 3);
                 chk("t6_pass",   if_c.pass, 0);
    step(2);
    kick_c();
    chk("t6_rdone", if_c.done, 0);
    chk("t6_rbusy", if_c.busy, 1);
    chk("t6_rerr",  if_c.err_count, 0);
    to_edge(19); chk("t6_done2", if_c.done, 1);
                 chk("t6_err2",  if_c.err_count, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ff_bist.md
Name: ff_bist

Overview:
- Synthesizable built-in self-test engine that drives and checks a single-bit registered storage element (`d_ff` or a sibling flip-flop wired as a D path).
- It replaces a hand-written stimulus bench with hardware: it resets the DUT, drives a pseudo-random bit stream on `d`, samples `q` one cycle later, counts mismatches and reports pass/fail.
- It sits beside the flip-flop under test on an FPGA or silicon test harness.

Parameters:
- NUM_VECTORS, 16: number of data vectors driven in RUN; legal range 1..255.
- LFSR_SEED, 8'hA5: initial LFSR state; a seed of 0 is replaced by 8'h01.
- CNT_W, 8: width of `err_count`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that launches a test; ignored while `busy`=1.
- dut_rst  out  1  active-high reset driven to the DUT.
- dut_d  out  1  data driven to the DUT, registered.
- dut_q  in  1  DUT output.
- busy  out  1  high from the start-sampling edge until DONE is entered.
- done  out  1  high in DONE; held until the next accepted start.
- pass  out  1  equals done AND (err_count == 0).
- err_count  out  CNT_W  mismatch count; saturates at all-ones.

Behaviour:
- Reset (rst=0): asynchronous, effective immediately, including mid-test. After reset:
  - state=IDLE; lfsr=seed; dut_rst=0; dut_d=0; busy=0; done=0; err_count=0.
  - The vector counter and d_prev are also 0.
- States: IDLE, RST_DUT, RUN, FLUSH, DONE. Edge 0 is the edge that samples start=1.
- IDLE / DONE + start:
  - Go to RST_DUT at edge 0.
  - Clear err_count and done; reload lfsr; set busy=1; set dut_rst=1.
- RST_DUT: lasts 2 cycles (after edge 0 and after edge 1).
  - dut_d=0 throughout.
  - In the 2nd cycle, dut_q must be 0; otherwise err_count increments at edge 2.
  - Edge 2: go to RUN and set dut_rst=0.
- RUN: lasts NUM_VECTORS cycles (edges 2..NUM_VECTORS+1).
  - At each RUN edge: dut_d <= lfsr[7]; lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; d_prev <= dut_d.
- Compare rule: in every cycle after the first RUN cycle (RUN cycles 2..N, then FLUSH), dut_q is compared with d_prev.
  - On mismatch, err_count increments at the closing edge.
  - Total compares = NUM_VECTORS.
- FLUSH: 1 cycle; compares the last vector.
  - Edge NUM_VECTORS+3: go to DONE, done=1, busy=0.
  - For the defaults, done rises after edge 19.
- err_count saturates: no wrap at 2^CNT_W - 1.
- start while busy=1: ignored, with no restart and no side effects.
- start in DONE: restarts the test.
- dut_d is held at its last value in FLUSH/DONE.

Decomposition:
- Package ff_bist_pkg:
  - State enum (IDLE, RST_DUT, RUN, FLUSH, DONE).
  - LFSR tap mask 8'hB8 and the default seed.
  - RST_CYCLES=2.
- Sub-module lfsr8:
  - Inputs: clk, rst, load, en, seed.
  - Output: 8-bit state.
  - Seed-0 guard applied inside.
- FSM, counters and compare logic live in ff_bist.

Test Plan:
- Good DUT (`d_ff`: q<=d, async reset to 0), defaults, start at cycle 5 -> busy=1 after start edge; done=1 and pass=1 exactly 19 edges after start; err_count=0.
- Inverted DUT (q<=~d, reset q=0) -> reset check passes; err_count=16; pass=0.
- Good DUT with q forced inverted for one cycle during the 5th compare -> err_count=1; pass=0.
- DUT stuck-at-1 with NUM_VECTORS=1 -> reset-check error plus 0 or 1 data error; bench model must match exactly; done at edge 4 after start.
- rst=0 asserted mid-RUN (edge 8), released 3 cycles later -> all outputs at reset values immediately; no done; a fresh start completes with pass=1.
- start pulsed again during RUN and in DONE, with CNT_W=2 and the inverted DUT -> the RUN pulse is ignored; the DONE pulse restarts (done clears); err_count saturates at 3.
